// File: rtl/kf8253_counter_channel.sv
// kf8253_counter_channel
// One 16-bit 8253 counter channel. It takes the decoded strobes and the latched
// data byte from the bus control logic, and it produces the channel OUT waveform
// and the byte returned on counter reads. It supports modes 0, 2 and 3, the
// counter-latch command, and LSB / MSB / LSB-then-MSB access. Counting is always
// binary: the BCD bit of the control word is accepted but has no effect.
//
// Ports:
//   clock              system clock; all state updates on the rising edge
//   reset              synchronous, active-high
//   internal_data_bus  last written bus byte, stable while a write strobe is high
//   write_control      one-cycle pulse: control word for this channel
//   write_counter      one-cycle pulse: count byte for this channel
//   read_counter       level, high while this channel is being read
//   counter_clock      channel CLK, synchronous to clock, each level held >= 1 clock
//   counter_gate       channel GATE, synchronous to clock
//   counter_out        channel OUT (registered)
//   read_data          byte presented for the current read
module kf8253_counter_channel (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] internal_data_bus,
  input  logic       write_control,
  input  logic       write_counter,
  input  logic       read_counter,
  input  logic       counter_clock,
  input  logic       counter_gate,
  output logic       counter_out,
  output logic [7:0] read_data
);

  typedef enum logic [1:0] {
    MODE0 = 2'd0,
    MODE2 = 2'd1,
    MODE3 = 2'd2
  } mode_t;

  // Modes 6/7 alias to 2/3; modes 1, 4 and 5 behave as mode 0.
  function automatic mode_t decode_mode(input logic [2:0] mode_field);
    mode_t result;
    case (mode_field[1:0])
      2'b10:   result = MODE2;
      2'b11:   result = MODE3;
      default: result = MODE0;
    endcase
    return result;
  endfunction

  logic [1:0]  rw_r;
  mode_t       mode_r;
  logic [15:0] n_r;              // count register written by the CPU
  logic [15:0] count_r;          // counting element
  logic [15:0] latched_count_r;
  logic        latched_r;
  logic        write_msb_r;      // next count byte of an RW=11 pair is the MSB
  logic        read_msb_r;       // next read byte of an RW=11 pair is the MSB
  logic        load_pending_r;
  logic        counting_r;
  logic        out_r;
  logic        prev_clk_r;
  logic        prev_gate_r;
  logic        prev_read_r;

  logic        count_event_s;
  logic        gate_rise_s;
  logic        read_done_s;
  logic [15:0] load_value_s;
  logic [15:0] half_s;
  logic [15:0] count_dec_s;
  logic [15:0] source_s;
  mode_t       ctrl_mode_s;

  assign count_event_s = prev_clk_r & ~counter_clock;
  assign gate_rise_s   = counter_gate & ~prev_gate_r;
  assign read_done_s   = prev_read_r & ~read_counter;
  assign ctrl_mode_s   = decode_mode(internal_data_bus[3:1]);
  assign counter_out   = out_r;

  // Reload value, mode 3 half-period threshold and decremented count.
  always_comb begin
    load_value_s = n_r;
    half_s       = 16'h0000;
    count_dec_s  = count_r - 16'd1;
    // N=1 runs as N=2 in the periodic modes.
    if ((mode_r != MODE0) && (n_r == 16'd1)) begin
      load_value_s = 16'd2;
    end else begin
      load_value_s = n_r;
    end
    // OUT stays high while the count is above floor(N/2); N=0 stands for 65536.
    if (load_value_s == 16'd0) begin
      half_s = 16'h8000;
    end else begin
      half_s = {1'b0, load_value_s[15:1]};
    end
  end

  // Read byte selection from the latch or the live counting element.
  always_comb begin
    source_s  = count_r;
    read_data = 8'h00;
    if (latched_r) begin
      source_s = latched_count_r;
    end else begin
      source_s = count_r;
    end
    if ((rw_r == 2'b10) || ((rw_r == 2'b11) && read_msb_r)) begin
      read_data = source_s[15:8];
    end else begin
      read_data = source_s[7:0];
    end
  end

  // Channel state: control words, count writes, counting, gate and read tracking.
  always_ff @(posedge clock) begin
    if (reset) begin
      rw_r            <= 2'b11;
      mode_r          <= MODE0;
      n_r             <= 16'h0000;
      count_r         <= 16'h0000;
      latched_count_r <= 16'h0000;
      latched_r       <= 1'b0;
      write_msb_r     <= 1'b0;
      read_msb_r      <= 1'b0;
      load_pending_r  <= 1'b0;
      counting_r      <= 1'b0;
      out_r           <= 1'b0;
      prev_clk_r      <= 1'b0;
      prev_gate_r     <= 1'b0;
      prev_read_r     <= 1'b0;
    end else begin
      prev_clk_r  <= counter_clock;
      prev_gate_r <= counter_gate;
      prev_read_r <= read_counter;

      // A control write, including the latch command, discards a coincident count event.
      if (write_control) begin
        if (internal_data_bus[5:4] == 2'b00) begin
          if (!latched_r) begin
            latched_count_r <= count_r;
            latched_r       <= 1'b1;
          end
        end else begin
          rw_r           <= internal_data_bus[5:4];
          mode_r         <= ctrl_mode_s;
          write_msb_r    <= 1'b0;
          read_msb_r     <= 1'b0;
          latched_r      <= 1'b0;
          counting_r     <= 1'b0;
          load_pending_r <= 1'b0;
          out_r          <= (ctrl_mode_s == MODE0) ? 1'b0 : 1'b1;
        end
      end else begin
        if (count_event_s) begin
          if (load_pending_r) begin
            count_r        <= load_value_s;
            load_pending_r <= 1'b0;
            counting_r     <= 1'b1;
            if (mode_r != MODE0) begin
              out_r <= 1'b1;
            end
          end else if (counting_r && counter_gate) begin
            case (mode_r)
              MODE2: begin
                if (count_r == 16'd1) begin
                  count_r <= load_value_s;
                  out_r   <= 1'b1;
                end else begin
                  count_r <= count_dec_s;
                  out_r   <= (count_dec_s != 16'd1);
                end
              end
              MODE3: begin
                if (count_r == 16'd1) begin
                  count_r <= load_value_s;
                  out_r   <= 1'b1;
                end else begin
                  count_r <= count_dec_s;
                  out_r   <= (count_dec_s > half_s);
                end
              end
              default: begin
                // Mode 0 keeps wrapping through FFFF; OUT only ever rises here.
                count_r <= count_dec_s;
                if (count_r == 16'd1) begin
                  out_r <= 1'b1;
                end
              end
            endcase
          end
        end

        // In the periodic modes a low gate holds OUT high and a rising gate restarts.
        if (mode_r != MODE0) begin
          if (!counter_gate) begin
            out_r <= 1'b1;
          end
          if (gate_rise_s && counting_r) begin
            load_pending_r <= 1'b1;
          end
        end

        if (write_counter) begin
          case (rw_r)
            2'b01: begin
              n_r            <= {8'h00, internal_data_bus};
              load_pending_r <= 1'b1;
              if (mode_r == MODE0) begin
                out_r <= 1'b0;
              end
            end
            2'b10: begin
              n_r            <= {internal_data_bus, 8'h00};
              load_pending_r <= 1'b1;
              if (mode_r == MODE0) begin
                out_r <= 1'b0;
              end
            end
            default: begin
              if (!write_msb_r) begin
                // First byte of a pair: never load a half-written count.
                n_r[7:0]       <= internal_data_bus;
                write_msb_r    <= 1'b1;
                load_pending_r <= 1'b0;
                if (mode_r == MODE0) begin
                  out_r      <= 1'b0;
                  counting_r <= 1'b0;
                end
              end else begin
                n_r[15:8]      <= internal_data_bus;
                write_msb_r    <= 1'b0;
                load_pending_r <= 1'b1;
                if (mode_r == MODE0) begin
                  out_r <= 1'b0;
                end
              end
            end
          endcase
        end

        // The end of a read access steps the pointer and releases the latch after the last byte.
        if (read_done_s) begin
          if (rw_r == 2'b11) begin
            read_msb_r <= ~read_msb_r;
            if (read_msb_r) begin
              latched_r <= 1'b0;
            end
          end else begin
            latched_r <= 1'b0;
          end
        end
      end
    end
  end

endmodule
